// File: rtl/vc_pkg.sv
// Shared constants for the per-channel FIFOs and the demux that feeds them.
package vc_pkg;

    localparam int DATA_WIDTH_DEFAULT = 6;
    localparam int ADDR_WIDTH_DEFAULT = 4;

    // Bit of each word that carries the virtual-channel identifier.
    localparam int VC_ID_BIT = 5;

    localparam int UMBRAL_AF_DEFAULT = 14;
    localparam int UMBRAL_AE_DEFAULT = 2;

endpackage

// File: rtl/vc_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, registered read port.
module vc_fifo_mem
    import vc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Contents are never cleared; the pointers keep stale entries unreachable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vc_fifo.sv
// Per-virtual-channel FIFO: pointer, occupancy, threshold flags and sticky
// overflow tracking around a registered-read memory.
module vc_fifo
    import vc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic [ADDR_WIDTH:0]   umbral_almost_full,
    input  logic [ADDR_WIDTH:0]   umbral_almost_empty,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  push_ok;
    logic                  pop_ok;

    // Handshake: push is accepted when !full, pop when !empty, both judged on
    // the registered count, so a word cannot be read in its write cycle and a
    // pop frees no room for a push in the same cycle. Rejected pushes set error.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= umbral_almost_full);
    assign almost_empty = (count <= umbral_almost_empty);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            valid_out <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full) begin
                error <= 1'b1;
            end
        end
    end

    vc_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .reset(reset),
        .we   (push_ok),
        .waddr(wr_ptr),
        .wdata(data_in),
        .re   (pop_ok),
        .raddr(rd_ptr),
        .rdata(data_out)
    );

endmodule

// File: tb/tb_vc_fifo.sv
// Self-checking bench for vc_fifo: queue-based reference model with an
// expected-output scoreboard, directed scenarios plus a random phase.
module tb_vc_fifo;

    localparam int W     = 6;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          reset;
    logic          push;
    logic [W-1:0]  data_in;
    logic          pop;
    logic [AW:0]   umbral_almost_full;
    logic [AW:0]   umbral_almost_empty;
    logic [W-1:0]  data_out;
    logic          valid_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          error;

    vc_fifo #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk                (clk),
        .reset              (reset),
        .push               (push),
        .data_in            (data_in),
        .pop                (pop),
        .umbral_almost_full (umbral_almost_full),
        .umbral_almost_empty(umbral_almost_empty),
        .data_out           (data_out),
        .valid_out          (valid_out),
        .full               (full),
        .empty              (empty),
        .almost_full        (almost_full),
        .almost_empty       (almost_empty),
        .error              (error)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model and scoreboard
    logic [W-1:0] model_fifo[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_last;
    int           m_count;
    logic         m_error;
    int           n_tests;
    int           n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_flags();
        check("empty",        32'(empty),        32'(m_count == 0));
        check("full",         32'(full),         32'(m_count == DEPTH));
        check("almost_full",  32'(almost_full),  32'(m_count >= int'(umbral_almost_full)));
        check("almost_empty", 32'(almost_empty), 32'(m_count <= int'(umbral_almost_empty)));
        check("error",        32'(error),        32'(m_error));
    endtask

    // Drivers
    task automatic apply_reset(input logic p, input logic [W-1:0] d);
        reset   = 1'b0;
        push    = p;
        data_in = d;
        pop     = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        push  = 1'b0;
        model_fifo.delete();
        exp_q.delete();
        m_count = 0;
        m_error = 1'b0;
        m_last  = '0;
        check("rst_valid_out", 32'(valid_out), 32'(0));
        check("rst_data_out",  32'(data_out),  32'(0));
        check_flags();
    endtask

    task automatic drive_cycle(input logic p, input logic [W-1:0] d, input logic q);
        logic push_ok;
        logic pop_ok;
        push_ok = p && (m_count < DEPTH);
        pop_ok  = q && (m_count > 0);
        if (p && !push_ok) m_error = 1'b1;
        if (pop_ok) exp_q.push_back(model_fifo.pop_front());
        if (push_ok) model_fifo.push_back(d);
        m_count = m_count + int'(push_ok) - int'(pop_ok);
        push    = p;
        data_in = d;
        pop     = q;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        check("valid_out", 32'(valid_out), 32'(pop_ok));
        if (pop_ok) m_last = exp_q.pop_front();
        check("data_out", 32'(data_out), 32'(m_last));
        check_flags();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_count = 0;
        m_error = 1'b0;
        m_last  = '0;
        reset   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        umbral_almost_full  = 5'd14;
        umbral_almost_empty = 5'd2;

        // Reset and idle
        apply_reset(1'b0, '0);
        apply_reset(1'b0, '0);
        drive_cycle(1'b0, '0, 1'b0);

        // Fill to full, overflow, push+pop while full, then drain
        for (int i = 1; i <= 16; i++) drive_cycle(1'b1, W'(i), 1'b0);
        drive_cycle(1'b1, 6'h3F, 1'b0);
        drive_cycle(1'b1, 6'h3E, 1'b1);
        for (int i = 0; i < 15; i++) drive_cycle(1'b0, '0, 1'b1);
        drive_cycle(1'b0, '0, 1'b1);
        drive_cycle(1'b0, '0, 1'b0);

        // Simultaneous push and pop while empty
        apply_reset(1'b0, '0);
        drive_cycle(1'b1, 6'h05, 1'b1);
        drive_cycle(1'b0, '0, 1'b1);

        // Fill 8, threshold edges, sustained push+pop across pointer wrap
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, W'(6'h10 + i), 1'b0);
        umbral_almost_full  = 5'd8;
        umbral_almost_empty = 5'd7;
        #1 check_flags();
        umbral_almost_full  = 5'd9;
        umbral_almost_empty = 5'd8;
        #1 check_flags();
        umbral_almost_full  = 5'd14;
        umbral_almost_empty = 5'd2;
        #1 check_flags();
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, W'(6'h20 + i), 1'b1);
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, '0, 1'b1);

        // Reset with push mid-operation
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, W'(6'h30 + i), 1'b0);
        apply_reset(1'b1, 6'h11);
        drive_cycle(1'b1, 6'h2A, 1'b0);
        drive_cycle(1'b0, '0, 1'b1);

        // Random traffic with random thresholds
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 0) begin
                umbral_almost_full  = 5'($urandom_range(1, DEPTH));
                umbral_almost_empty = 5'($urandom_range(0, DEPTH - 1));
            end
            drive_cycle(1'($urandom_range(0, 1)), W'($urandom_range(0, 63)),
                        1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
